// File: rtl/operand_recover_pkg.sv
// Shared types and width constants for the operand recovery block.
// The accumulator is three bits wider than an operand so every intermediate stays exact.
package operand_recover_pkg;
  localparam int W_DEF     = 8;
  localparam int SUM_W_DEF = W_DEF + 2;
  localparam int ACC_W_DEF = W_DEF + 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SUB_A = 3'd1,
    SUB_B = 3'd2,
    SUB_C = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/operand_recover_if.sv
// Request/result bus. A transfer on either side happens on a rising clk edge where
// valid and ready are both 1; the source holds its payload steady until then.
interface operand_recover_if
  import operand_recover_pkg::*;
#(
  parameter int W = W_DEF
) ();
  logic           in_valid;
  logic           in_ready;
  logic [W+1:0]   sum;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   c;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   d;
  logic           err;

  modport master (
    output in_valid, sum, a, b, c, out_ready,
    input  in_ready, out_valid, d, err
  );

  modport slave (
    input  in_valid, sum, a, b, c, out_ready,
    output in_ready, out_valid, d, err
  );
endinterface

// File: rtl/operand_recover_sub_stage.sv
// Shared combinational subtractor: two's-complement accumulator minus a zero-extended operand.
module sub_stage
  import operand_recover_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W+2:0] acc,
  input  logic [W-1:0] op,
  output logic [W+2:0] diff
);
  assign diff = acc - {3'b000, op};
endmodule

// File: rtl/operand_recover.sv
// Recovers d = sum - a - b - c with one shared subtractor, one operand per cycle,
// flagging err when the result falls outside 0..2^W-1.
module operand_recover
  import operand_recover_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  operand_recover_if.slave  bus,
  output state_t            state
);
  localparam int AW = W + 3;

  state_t          state_q;
  state_t          next_state;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   diff;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    c_q;
  logic [W-1:0]    op_sel;
  logic [W-1:0]    d_q;
  logic            err_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            accept;
  logic            release_out;
  logic            final_err;

  assign accept      = (state_q == IDLE) && bus.in_valid && in_ready_q;
  assign release_out = (state_q == DONE) && out_valid_q && bus.out_ready;

  always_comb begin
    op_sel = '0;
    unique case (state_q)
      SUB_A:   op_sel = a_q;
      SUB_B:   op_sel = b_q;
      SUB_C:   op_sel = c_q;
      default: op_sel = '0;
    endcase
  end

  sub_stage #(.W(W)) u_sub (
    .acc  (acc_q),
    .op   (op_sel),
    .diff (diff)
  );

  // Out of range means negative (sign bit) or any bit set above the operand width.
  assign final_err = diff[AW-1] | (|diff[W+1:W]);

  always_comb begin
    next_state = state_q;
    unique case (state_q)
      IDLE:    if (accept) next_state = SUB_A;
      SUB_A:   next_state = SUB_B;
      SUB_B:   next_state = SUB_C;
      SUB_C:   next_state = DONE;
      DONE:    if (release_out) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= next_state;
  end

  // Handshake flags are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      err_q       <= 1'b0;
    end else begin
      in_ready_q  <= (next_state == IDLE);
      out_valid_q <= (next_state == DONE);
      if (accept) begin
        acc_q <= {1'b0, bus.sum};
        a_q   <= bus.a;
        b_q   <= bus.b;
        c_q   <= bus.c;
      end
      if (state_q == SUB_A || state_q == SUB_B || state_q == SUB_C) begin
        acc_q <= diff;
      end
      if (state_q == SUB_C) begin
        err_q <= final_err;
        d_q   <= final_err ? '0 : diff[W-1:0];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.d         = d_q;
  assign bus.err       = err_q;
  assign state         = state_q;
endmodule

// File: tb/tb_operand_recover.sv
// Directed bench for operand_recover: table of single transactions plus
// backpressure, mid-operation reset and back-to-back sequences.
module tb_operand_recover;
  import operand_recover_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W+1:0] sum;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] exp_d;
    logic         exp_err;
  } vec_t;

  logic   clk;
  logic   rst;
  state_t state;
  int     n_chk;
  int     n_pass;
  logic [W-1:0] exp_q[$];

  operand_recover_if #(.W(W)) bus ();

  operand_recover #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic drive_req(input vec_t v);
    bus.sum      = v.sum;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.c        = v.c;
    bus.in_valid = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge right after the acceptance edge.
  task automatic wait_accept(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({name, "_accept_timeout"}, 0, 1);
  endtask

  // Acceptance edge T0; DONE entered on edge T0+3 (acceptance edge counted as the first).
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    bus.out_ready = 1'b0;
    drive_req(v);
    wait_accept(tag);
    bus.in_valid = 1'b0;
    check({tag, "_state_sub_a"}, 32'(state), 32'(SUB_A));
    @(negedge clk);
    @(negedge clk);
    check({tag, "_out_valid_early"}, 32'(bus.out_valid), 0);
    @(negedge clk);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_d"}, 32'(bus.d), 32'(v.exp_d));
    check({tag, "_err"}, 32'(bus.err), 32'(v.exp_err));
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_out_valid_after"}, 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vec_t bp_v;
    vec_t nx_v;
    vec_t b2b[3];
    int   idx;
    int   n_res;
    int   last_hs;
    int   ov_seen;
    logic acc_now;
    logic hs_now;

    n_chk  = 0;
    n_pass = 0;

    vecs[0] = '{sum: 10'd510,  a: 8'd255, b: 8'd0,   c: 8'd0,   exp_d: 8'd255, exp_err: 1'b0};
    vecs[1] = '{sum: 10'd1020, a: 8'd255, b: 8'd255, c: 8'd255, exp_d: 8'd255, exp_err: 1'b0};
    vecs[2] = '{sum: 10'd3,    a: 8'd1,   b: 8'd1,   c: 8'd1,   exp_d: 8'd0,   exp_err: 1'b0};
    vecs[3] = '{sum: 10'd2,    a: 8'd1,   b: 8'd1,   c: 8'd1,   exp_d: 8'd0,   exp_err: 1'b1};
    vecs[4] = '{sum: 10'd1023, a: 8'd0,   b: 8'd0,   c: 8'd0,   exp_d: 8'd0,   exp_err: 1'b1};
    vecs[5] = '{sum: 10'd100,  a: 8'd10,  b: 8'd20,  c: 8'd30,  exp_d: 8'd40,  exp_err: 1'b0};
    vecs[6] = '{sum: 10'd0,    a: 8'd255, b: 8'd255, c: 8'd255, exp_d: 8'd0,   exp_err: 1'b1};
    vecs[7] = '{sum: 10'd300,  a: 8'd20,  b: 8'd30,  c: 8'd50,  exp_d: 8'd200, exp_err: 1'b0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sum       = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c         = '0;

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_d", 32'(bus.d), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 1);

    // table-driven single transactions
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // backpressure with a held next request
    bp_v = '{sum: 10'd400, a: 8'd100, b: 8'd50, c: 8'd25, exp_d: 8'd225, exp_err: 1'b0};
    nx_v = '{sum: 10'd10,  a: 8'd1,   b: 8'd2,  c: 8'd3,  exp_d: 8'd4,   exp_err: 1'b0};
    drive_req(bp_v);
    wait_accept("bp");
    drive_req(nx_v);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_d", 32'(bus.d), 32'(bp_v.exp_d));
      check("bp_err", 32'(bus.err), 0);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_release_out_valid", 32'(bus.out_valid), 0);
    check("bp_release_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    check("bp_next_accepted", 32'(state), 32'(SUB_A));
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_next_out_valid", 32'(bus.out_valid), 1);
    check("bp_next_d", 32'(bus.d), 32'(nx_v.exp_d));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // reset pulsed while in SUB_B; bus.d currently holds 4 from the last result
    drive_req(vecs[7]);
    wait_accept("rst_mid");
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_in_sub_b", 32'(state), 32'(SUB_B));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_state", 32'(state), 32'(IDLE));
    @(negedge clk);
    check("rst_mid_in_ready", 32'(bus.in_ready), 1);
    check("rst_mid_out_valid", 32'(bus.out_valid), 0);
    check("rst_mid_d", 32'(bus.d), 0);
    check("rst_mid_err", 32'(bus.err), 0);
    ov_seen = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid === 1'b1) ov_seen++;
      @(negedge clk);
    end
    check("rst_mid_no_result", 32'(ov_seen), 0);

    // back-to-back with in_valid held and out_ready tied high
    b2b[0] = '{sum: 10'd50,  a: 8'd10,  b: 8'd10,  c: 8'd10, exp_d: 8'd20,  exp_err: 1'b0};
    b2b[1] = '{sum: 10'd600, a: 8'd200, b: 8'd100, c: 8'd50, exp_d: 8'd250, exp_err: 1'b0};
    b2b[2] = '{sum: 10'd8,   a: 8'd1,   b: 8'd2,   c: 8'd3,  exp_d: 8'd2,   exp_err: 1'b0};
    for (int i = 0; i < 3; i++) exp_q.push_back(b2b[i].exp_d);
    idx     = 0;
    n_res   = 0;
    last_hs = -1;
    drive_req(b2b[0]);
    for (int cyc = 0; cyc < 60 && n_res < 3; cyc++) begin
      acc_now = bus.in_valid & bus.in_ready;
      hs_now  = bus.out_valid & bus.out_ready;
      if (hs_now === 1'b1) begin
        check("b2b_d", 32'(bus.d), 32'(exp_q.pop_front()));
        check("b2b_err", 32'(bus.err), 0);
        if (last_hs >= 0) check("b2b_spacing", 32'(cyc - last_hs), 5);
        last_hs = cyc;
        n_res++;
      end
      @(negedge clk);
      if (acc_now === 1'b1) begin
        idx++;
        if (idx < 3) drive_req(b2b[idx]);
        else bus.in_valid = 1'b0;
      end
    end
    check("b2b_result_count", 32'(n_res), 3);
    bus.out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/operand_recover.md
OPERAND_RECOVER -- requirements
Module: operand_recover

Interface
REQ-001 Parameter W, default 8: operand width; the sum width SHALL be W+2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 sum  input  W+2  four-operand sum (a+b+c+d).
REQ-007 a, b, c  input  W each  three known operands.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 d  output  W  recovered fourth operand.
REQ-011 err  output  1  sum is inconsistent with the operands (the recovered d lies outside 0..2^W-1).

Function
REQ-012 The FSM SHALL have exactly five states: IDLE, SUB_A, SUB_B, SUB_C, DONE.
REQ-013 The block SHALL assert in_ready only in IDLE; a request SHALL be accepted on a clk edge where in_valid and in_ready are both 1.
REQ-014 On acceptance, the block SHALL load sum, zero-extended, into a W+3-bit two's-complement accumulator, SHALL register a, b and c, and SHALL go to SUB_A.
REQ-015 In each of SUB_A, SUB_B and SUB_C, the block SHALL subtract the matching registered operand from the accumulator, zero-extended, and SHALL advance one state per cycle.
REQ-016 On leaving SUB_C, the block SHALL set err=1 iff the final accumulator is negative or greater than 2^W-1.
REQ-017 On leaving SUB_C, the block SHALL set d to accumulator[W-1:0] when err=0, and to 0 when err=1.
REQ-018 On leaving SUB_C, the block SHALL enter DONE.
REQ-019 out_valid SHALL be 1 exactly in DONE, starting 4 clk edges after the acceptance edge.
REQ-020 In DONE, d and err SHALL stay stable until the handshake completes, i.e. out_valid and out_ready are both 1 on the same clk edge.
REQ-021 On that completing edge, the block SHALL return to IDLE.
REQ-022 The minimum initiation interval SHALL be 5 cycles, and there SHALL be no overlap between requests.
REQ-023 in_valid asserted outside IDLE SHALL be ignored, with no queuing; the source holds the request until in_ready.
REQ-024 out_ready asserted outside DONE SHALL have no effect.
REQ-025 The arithmetic SHALL be exact for all inputs: sum up to 2^(W+2)-1 with a=b=c=0, and a=b=c=2^W-1 with sum=0, SHALL neither wrap nor overflow the accumulator.

Reset
REQ-026 When rst=1 at a clk edge, the FSM SHALL go to IDLE regardless of state, including mid-subtraction and DONE with out_ready low.
REQ-027 Reset SHALL clear in_ready to 0, out_valid to 0, d to 0, err to 0, the accumulator to 0 and the operand registers to 0.
REQ-028 A request in flight during reset SHALL be discarded with no output handshake.
REQ-029 in_ready SHALL be 1 on the first edge after rst deasserts.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, SUB_A, SUB_B, SUB_C, DONE) and the width constants (default W, W+2, W+3).
REQ-031 Exactly one W+3-bit subtractor SHALL be instantiated and shared across SUB_A, SUB_B and SUB_C, selected by an operand mux.
REQ-032 The subtractor SHALL be the sub-module sub_stage: combinational, inputs acc (W+3) and op (W), output acc minus zero-extended op.
REQ-033 No other sub-modules SHALL be used.

Verification
REQ-034 Exact recovery: sum=510, a=255, b=0, c=0 -> out_valid 4 edges after acceptance, d=255, err=0.
REQ-035 Maximum inputs: sum=1020, a=b=c=255 -> d=255, err=0; sum=3, a=b=c=1 -> d=0, err=0.
REQ-036 Inconsistency: sum=2, a=b=c=1 -> err=1, d=0 (negative); sum=1023, a=b=c=0 -> err=1, d=0 (exceeds 255).
REQ-037 Backpressure: out_ready held low 6 cycles in DONE -> out_valid, d and err stable; in_ready=0 throughout; a held in_valid is accepted on the edge after the output handshake.
REQ-038 Reset mid-operation: rst pulsed one cycle in SUB_B -> next cycle IDLE with in_ready=1, out_valid=0, d=0, err=0, and no result ever emitted for the aborted request.
REQ-039 Back-to-back: in_valid held high with 3 distinct requests and out_ready tied 1 -> results in order, spaced 5 cycles apart, every d correct.
